// File: rtl/spi_xfer_arb_pkg.sv
// Shared types and SPI register map for the two-requester SPI transfer arbiter.
package spi_xfer_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSsOn,
    StTxWr,
    StGuard,
    StPoll,
    StRxRd,
    StSsOff,
    StDone
  } xfer_state_e;

  localparam logic        SpiAddrCtl    = 1'b0;
  localparam logic        SpiAddrData   = 1'b1;
  localparam int unsigned StatusBusyBit = 7;
  localparam int unsigned CtlSsBit      = 0;

  // Control-register write value with only the slave-select bit driven.
  function automatic logic [7:0] ctl_word(input logic ss);
    logic [7:0] w;
    w           = 8'h00;
    w[CtlSsBit] = ss;
    return w;
  endfunction

endpackage

// File: rtl/spi_xfer_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, registered last-served pointer.
module spi_xfer_arb_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = served_i;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_xfer_arb.sv
// Arbitrates two requesters onto one register-mapped SPI master and sequences each transfer.
module spi_xfer_arb
  import spi_xfer_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned LEN_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic [7:0]       i_tx_dat0,
  input  logic [7:0]       i_tx_dat1,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_tx_rdy,
  output logic [1:0]       o_rx_vld,
  output logic [7:0]       o_rx_dat,
  output logic [1:0]       o_done,
  output logic             o_spi_addr,
  output logic             o_spi_cs,
  output logic             o_spi_we,
  output logic [7:0]       o_spi_dat,
  input  logic [7:0]       i_spi_dat
);

  // GUARD_CYCLES must be at least 1.
  localparam int unsigned GcW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GcW-1:0] GcLast = GcW'(GUARD_CYCLES - 1);

  xfer_state_e      state_q, state_d;
  logic             owner_q, owner_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [GcW-1:0]   gcnt_q, gcnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [7:0]       rx_dat_q, rx_dat_d;
  logic [1:0]       arb_gnt;
  logic             arb_upd;
  logic [1:0]       owner_oh;

  spi_xfer_arb_rr_arb2 u_rr_arb2 (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .req_i    (i_req),
    .upd_i    (arb_upd),
    .served_i (owner_q),
    .gnt_o    (arb_gnt)
  );

  assign owner_oh = owner_q ? 2'b10 : 2'b01;
  assign o_gnt    = gnt_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gcnt_d     = gcnt_q;
    gnt_d      = gnt_q;
    rx_dat_d   = rx_dat_q;
    arb_upd    = 1'b0;
    o_spi_cs   = 1'b0;
    o_spi_we   = 1'b0;
    o_spi_addr = SpiAddrCtl;
    o_spi_dat  = 8'h00;
    o_tx_rdy   = 2'b00;
    o_rx_vld   = 2'b00;
    o_done     = 2'b00;
    o_rx_dat   = rx_dat_q;

    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          owner_d = arb_gnt[1];
          len_d   = arb_gnt[1] ? i_len1 : i_len0;
          idx_d   = '0;
          gnt_d   = arb_gnt;
          state_d = StSsOn;
        end
      end
      StSsOn: begin
        o_spi_cs  = 1'b1;
        o_spi_we  = 1'b1;
        o_spi_dat = ctl_word(1'b1);
        state_d   = StTxWr;
      end
      StTxWr: begin
        o_spi_cs   = 1'b1;
        o_spi_we   = 1'b1;
        o_spi_addr = SpiAddrData;
        o_spi_dat  = owner_q ? i_tx_dat1 : i_tx_dat0;
        o_tx_rdy   = owner_oh;
        gcnt_d     = '0;
        state_d    = StGuard;
      end
      StGuard: begin
        // Bus idle while the SPI block starts shifting; busy is not trustworthy yet.
        if (gcnt_q == GcLast) begin
          state_d = StPoll;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      StPoll: begin
        o_spi_cs = 1'b1;
        if (!i_spi_dat[StatusBusyBit]) begin
          state_d = StRxRd;
        end
      end
      StRxRd: begin
        o_spi_cs   = 1'b1;
        o_spi_addr = SpiAddrData;
        rx_dat_d   = i_spi_dat;
        o_rx_dat   = i_spi_dat;
        o_rx_vld   = owner_oh;
        if (idx_q == len_q) begin
          state_d = StSsOff;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StTxWr;
        end
      end
      StSsOff: begin
        o_spi_cs  = 1'b1;
        o_spi_we  = 1'b1;
        o_spi_dat = ctl_word(1'b0);
        state_d   = StDone;
      end
      StDone: begin
        o_done  = owner_oh;
        gnt_d   = 2'b00;
        arb_upd = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      gcnt_q   <= '0;
      gnt_q    <= 2'b00;
      rx_dat_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      gcnt_q   <= gcnt_d;
      gnt_q    <= gnt_d;
      rx_dat_q <= rx_dat_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Directed bench for spi_xfer_arb with a small loopback SPI register-port model.
module tb_spi_xfer_arb;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [1:0] i_req = 2'b00;
  logic [7:0] i_len0 = 8'h00;
  logic [7:0] i_len1 = 8'h00;
  logic [7:0] i_tx_dat0 = 8'h00;
  logic [7:0] i_tx_dat1;
  logic [1:0] o_gnt, o_tx_rdy, o_rx_vld, o_done;
  logic [7:0] o_rx_dat, o_spi_dat, i_spi_dat;
  logic       o_spi_addr, o_spi_cs, o_spi_we;

  always #5 i_clk = ~i_clk;

  spi_xfer_arb #(
    .GUARD_CYCLES (4),
    .LEN_W        (8)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_len0     (i_len0),
    .i_len1     (i_len1),
    .i_tx_dat0  (i_tx_dat0),
    .i_tx_dat1  (i_tx_dat1),
    .o_gnt      (o_gnt),
    .o_tx_rdy   (o_tx_rdy),
    .o_rx_vld   (o_rx_vld),
    .o_rx_dat   (o_rx_dat),
    .o_done     (o_done),
    .o_spi_addr (o_spi_addr),
    .o_spi_cs   (o_spi_cs),
    .o_spi_we   (o_spi_we),
    .o_spi_dat  (o_spi_dat),
    .i_spi_dat  (i_spi_dat)
  );

  // SPI port model: data written is looped back; busy counts down after each data write.
  logic       ss_m = 1'b0;
  logic [7:0] data_m = 8'h00;
  int         busy_m = 0;
  int         busy_set = 0;

  int cyc, poll_cnt, wr_cyc, guard_meas, lat_meas, polls_byte, last_polls;
  int ss_viol, rd_busy, first_poll_pending;
  int tx_cnt[2], rx_cnt[2], done_cnt[2];
  logic [7:0] rx_last[2];
  logic [7:0] ctl_log[$];
  logic [7:0] rx_log[$];

  logic [7:0] tx1_tab[4];
  int         tx1_base = 0;
  assign i_tx_dat1 = tx1_tab[2'(tx_cnt[1] - tx1_base)];

  always_comb begin
    i_spi_dat = 8'h00;
    if (o_spi_addr == 1'b0) begin
      i_spi_dat[7] = (busy_m != 0);
      i_spi_dat[0] = ss_m;
    end else begin
      i_spi_dat = data_m;
    end
  end

  always @(negedge i_clk) begin
    cyc++;
    if (i_reset) begin
      ss_m   = 1'b0;
      busy_m = 0;
      data_m = 8'h00;
    end else begin
      if (busy_m > 0) busy_m--;
      if (o_spi_cs && o_spi_we && !o_spi_addr) begin
        ctl_log.push_back(o_spi_dat);
        ss_m = o_spi_dat[0];
      end
      if (o_spi_cs && o_spi_we && o_spi_addr) begin
        if (!ss_m) ss_viol++;
        data_m = o_spi_dat;
        busy_m = busy_set;
        wr_cyc = cyc;
        polls_byte = 0;
        first_poll_pending = 1;
      end
      if (o_spi_cs && !o_spi_we && !o_spi_addr) begin
        poll_cnt++;
        polls_byte++;
        if (first_poll_pending != 0) begin
          guard_meas = cyc - wr_cyc - 1;
          first_poll_pending = 0;
        end
      end
      if (o_spi_cs && !o_spi_we && o_spi_addr) begin
        if (busy_m != 0) rd_busy++;
        lat_meas   = cyc - wr_cyc;
        last_polls = polls_byte;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (o_tx_rdy[i]) tx_cnt[i]++;
      if (o_rx_vld[i]) begin
        rx_cnt[i]++;
        rx_last[i] = o_rx_dat;
        rx_log.push_back(o_rx_dat);
      end
      if (o_done[i]) done_cnt[i]++;
    end
  end

  int total = 0;
  int bad = 0;
  int b_tx[2], b_rx[2], b_done[2];
  int cl, rl, sv, rb, pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_tx[i]   = tx_cnt[i];
      b_rx[i]   = rx_cnt[i];
      b_done[i] = done_cnt[i];
    end
    cl = ctl_log.size();
    rl = rx_log.size();
    sv = ss_viol;
    rb = rd_busy;
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (o_gnt == 2'b00 && k < 50);
    chk(tag, {30'd0, o_gnt}, {30'd0, exp});
  endtask

  task automatic wait_done(input string tag, input int idx, input int max);
    int d0 = done_cnt[0] + done_cnt[1];
    int di = done_cnt[idx];
    int k = 0;
    while ((done_cnt[0] + done_cnt[1]) == d0 && k < max) begin
      step(1);
      k++;
    end
    chk(tag, done_cnt[idx] - di, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx1_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    i_reset = 1'b1;
    step(3);
    chk("rst_gnt", {30'd0, o_gnt}, 0);
    chk("rst_done", {30'd0, o_done}, 0);
    chk("rst_spi", {22'd0, o_spi_cs, o_spi_we, o_spi_dat}, 0);
    chk("rst_rx", {20'd0, o_rx_vld, o_tx_rdy, o_rx_dat}, 0);
    i_reset = 1'b0;
    step(1);

    // Single byte from requester 0, looped back.
    snap();
    i_len0 = 8'd0;
    i_tx_dat0 = 8'hA5;
    i_req = 2'b01;
    wait_gnt("t1_gnt", 2'b01);
    i_req = 2'b00;
    wait_done("t1_done", 0, 60);
    chk("t1_tx_rdy", tx_cnt[0] - b_tx[0], 1);
    chk("t1_rx_vld", rx_cnt[0] - b_rx[0], 1);
    chk("t1_rx_dat", {24'd0, rx_last[0]}, 32'hA5);
    chk("t1_ctl_n", ctl_log.size() - cl, 2);
    chk("t1_ctl_on", {24'd0, ctl_log[cl]}, 32'h01);
    chk("t1_ctl_off", {24'd0, ctl_log[cl+1]}, 32'h00);
    chk("t1_guard", guard_meas, 4);
    chk("t1_latency", lat_meas, 6);
    chk("t1_polls", last_polls, 1);
    step(1);
    chk("t1_gnt_clr", {30'd0, o_gnt}, 0);

    // Simultaneous requests straight after reset.
    i_reset = 1'b1;
    step(2);
    i_reset = 1'b0;
    step(1);
    i_len0 = 8'd0;
    i_len1 = 8'd0;
    i_tx_dat0 = 8'h3C;
    tx1_base = tx_cnt[1];
    i_req = 2'b11;
    wait_gnt("tie1_gnt", 2'b01);
    i_req = 2'b10;
    wait_done("tie1_done", 0, 60);
    wait_gnt("tie2_gnt", 2'b10);
    i_req = 2'b00;
    wait_done("tie2_done", 1, 60);
    chk("tie_rx0", {24'd0, rx_last[0]}, 32'h3C);
    chk("tie_rx1", {24'd0, rx_last[1]}, 32'h11);
    i_req = 2'b11;
    wait_gnt("tie3_gnt", 2'b01);
    i_req = 2'b00;
    wait_done("tie3_done", 0, 60);

    // Three-byte transfer from requester 1.
    snap();
    tx1_base = tx_cnt[1];
    i_len1 = 8'd2;
    i_req = 2'b10;
    wait_gnt("t3_gnt", 2'b10);
    i_req = 2'b00;
    wait_done("t3_done", 1, 100);
    chk("t3_tx_rdy", tx_cnt[1] - b_tx[1], 3);
    chk("t3_rx_vld", rx_cnt[1] - b_rx[1], 3);
    chk("t3_rx_b0", {24'd0, rx_log[rl]}, 32'h11);
    chk("t3_rx_b1", {24'd0, rx_log[rl+1]}, 32'h22);
    chk("t3_rx_b2", {24'd0, rx_log[rl+2]}, 32'h33);
    chk("t3_ctl_n", ctl_log.size() - cl, 2);
    chk("t3_ss_held", ss_viol - sv, 0);
    chk("t3_no_done0", done_cnt[0] - b_done[0], 0);

    // Busy held for 40 cycles after the data write.
    busy_set = 40;
    snap();
    i_len0 = 8'd0;
    i_tx_dat0 = 8'h5A;
    i_req = 2'b01;
    wait_gnt("t4_gnt", 2'b01);
    i_req = 2'b00;
    wait_done("t4_done", 0, 120);
    chk("t4_polls", last_polls, 36);
    chk("t4_latency", lat_meas, 41);
    chk("t4_guard", guard_meas, 4);
    chk("t4_rd_busy", rd_busy - rb, 0);
    chk("t4_rx_dat", {24'd0, rx_last[0]}, 32'h5A);

    // Reset while polling, then recover.
    busy_set = 100;
    snap();
    i_tx_dat0 = 8'h77;
    i_req = 2'b01;
    wait_gnt("t5_gnt", 2'b01);
    i_req = 2'b00;
    pc = poll_cnt;
    for (int k = 0; k < 40 && poll_cnt == pc; k++) step(1);
    chk("t5_in_poll", {31'd0, poll_cnt != pc}, 1);
    i_reset = 1'b1;
    step(1);
    chk("t5_rst_outs", {5'd0, o_gnt, o_tx_rdy, o_rx_vld, o_done, o_rx_dat,
                        o_spi_cs, o_spi_we, o_spi_addr, o_spi_dat}, 0);
    i_reset = 1'b0;
    busy_set = 0;
    step(10);
    chk("t5_no_done", done_cnt[0] - b_done[0], 0);
    tx1_base = tx_cnt[1];
    i_len1 = 8'd0;
    i_req = 2'b10;
    wait_gnt("t5_regnt", 2'b10);
    i_req = 2'b00;
    wait_done("t5_redone", 1, 60);
    chk("t5_rx_dat", {24'd0, rx_last[1]}, 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arb.md
SPI_XFER_ARB -- requirements
Module: spi_xfer_arb

Interface
REQ-001 Parameter GUARD_CYCLES, default 4, cycles waited after a tx-register write before busy polling starts.
REQ-002 Parameter LEN_W, default 8, width of the per-request length field (bytes minus one).
REQ-003 i_clk  in  1  clock.
REQ-004 i_reset  in  1  reset: synchronous, active-high, on i_clk.
REQ-005 i_req  in  2  transfer request per requester; held high until o_gnt.
REQ-006 i_len0, i_len1  in  LEN_W  byte count minus one per requester (0 = 1 byte).
REQ-007 i_tx_dat0, i_tx_dat1  in  8  next byte to send per requester.
REQ-008 o_gnt  out  2  one-hot owner, high for the whole transfer.
REQ-009 o_tx_rdy  out  2  one-cycle pulse: owner's tx byte consumed this cycle.
REQ-010 o_rx_vld  out  2  one-cycle pulse: o_rx_dat valid for owner.
REQ-011 o_rx_dat  out  8  received byte, shared by both requesters.
REQ-012 o_done  out  2  one-cycle pulse at transfer end.
REQ-013 o_spi_addr, o_spi_cs, o_spi_we  out  1 each  SPI register port strobes (addr 0 ctl/status, addr 1 data).
REQ-014 o_spi_dat  out  8  write data to SPI port; i_spi_dat  in  8  combinational read data from SPI port.

Function
REQ-015 States: IDLE, SS_ON, TX_WR, GUARD, POLL, RX_RD, SS_OFF, DONE.
REQ-016 IDLE: any i_req bit -> latch winner and its length, set o_gnt, go SS_ON next cycle.
REQ-017 Arbitration round-robin over 2: a tie goes to the requester not served last; after reset requester 0 wins the first tie.
REQ-018 SS_ON: one cycle cs=1 we=1 addr=0 dat=0x01 -> TX_WR.
REQ-019 TX_WR: one cycle cs=1 we=1 addr=1 dat=owner tx byte, o_tx_rdy pulse for owner -> GUARD.
REQ-020 GUARD: exactly GUARD_CYCLES cycles with cs=0 -> POLL.
REQ-021 POLL: cs=1 we=0 addr=0 every cycle; i_spi_dat[7]=0 -> RX_RD, else stay.
REQ-022 RX_RD: cs=1 we=0 addr=1, capture i_spi_dat into o_rx_dat, o_rx_vld pulse; byte index == length -> SS_OFF, else increment index -> TX_WR.
REQ-023 SS_OFF: one cycle cs=1 we=1 addr=0 dat=0x00 -> DONE.
REQ-024 DONE: o_done pulse, o_gnt cleared, last-served pointer updated -> IDLE.
REQ-025 SS stays asserted across all bytes of one transfer; no ctl write between SS_ON and SS_OFF.
REQ-026 i_req dropped after grant is ignored; the transfer completes with the latched length.
REQ-027 Byte index is LEN_W bits; length all-ones transfers 2^LEN_W bytes without wrap error.
REQ-028 Outside the listed states o_spi_cs=0, o_spi_we=0, o_spi_dat=0.
REQ-029 Minimum per-byte latency TX_WR to RX_RD = GUARD_CYCLES + 2 cycles plus busy time.

Reset
REQ-030 i_reset: state IDLE, o_gnt/o_tx_rdy/o_rx_vld/o_done=0, o_rx_dat=0, SPI strobes 0, pointer = requester 1 last served.
REQ-031 Reset mid-transfer abandons it with no o_done; SS release relies on the SPI block's own reset.

Structure
REQ-032 Shared package holds the state enum, SPI register addresses (CTL=0, DATA=1), STATUS_BUSY_BIT=7, CTL_SS_BIT=0.
REQ-033 Sub-module rr_arb2 implements the 2-way round-robin winner/pointer logic.

Verification
REQ-034 Req0 len=0 tx=0xA5, MISO looped to MOSI -> one o_tx_rdy[0], o_rx_vld[0] with 0xA5, o_done[0]; ctl writes 0x01 then 0x00.
REQ-035 i_req=2'b11 at once after reset -> requester 0 served fully, then requester 1; next tie -> requester 0.
REQ-036 Req1 len=2 tx 0x11,0x22,0x33 -> three tx_rdy/rx_vld pairs, SS held high throughout, single o_done[1].
REQ-037 i_reset asserted in POLL -> next cycle all outputs 0, no o_done; new request afterwards completes normally.
REQ-038 Busy held high 40 cycles by model -> POLL reads continuously, no RX_RD until busy clears; GUARD measured as exactly 4 cycles.
